mc_residual_engine: RTL and testbench
=====================================

// Module: mc_residual_engine
// PURPOSE
// - Parametrised inter-prediction residual engine; successor to the 4-pixel/4-block motion-compensation stage.
// - Per row beat: builds prediction from one reference row, or from two averaged (bi-pred). Emits signed residual = curr - pred.
// - Accumulates one signed DC sum per sub-block and emits it on its own handshaked channel.
// - Feeds the forward transform; sits between the ref-fetch/ME stage and the transform/quant stage.
// PARAMETERS
// - PIXEL_WIDTH   8   bits per unsigned pixel
// - ROW_PIXELS    4   pixels per row beat (lanes)
// - ROWS_PER_BLK  4   rows per sub-block
// - N_BLK         4   sub-blocks per macroblock (per colour pass)
// - DC_WIDTH      16  signed DC sum width
//   - Elaboration error if DC_WIDTH < PIXEL_WIDTH+1+$clog2(ROW_PIXELS*ROWS_PER_BLK).
// PORTS
// - clk          in   1                          clock
// - reset        in   1                          synchronous, active-high reset
// - in_valid     in   1                          input row beat valid
// - in_ready     out  1                          input row beat accepted when in_valid&&in_ready
// - bipred       in   1                          1: pred=(ref0+ref1+1)>>1; 0: pred=ref0; sampled with beat
// - ccin         in   1                          chroma flag; sampled on first beat of a macroblock
// - curr_row     in   PIXEL_WIDTH*ROW_PIXELS     current pixels, lane 0 in LSBs
// - ref0_row     in   PIXEL_WIDTH*ROW_PIXELS     reference 0 pixels
// - ref1_row     in   PIXEL_WIDTH*ROW_PIXELS     reference 1 pixels; ignored when bipred=0
// - out_valid    out  1                          residual beat valid
// - out_ready    in   1                          downstream accepts residual beat
// - residual     out  (PIXEL_WIDTH+1)*ROW_PIXELS signed two's-complement residual per lane
// - out_last     out  1                          beat is last row of last sub-block of the macroblock
// - out_cc       out  1                          ccin latched for the current macroblock
// - dc_valid     out  1                          sub-block DC sum valid
// - dc_ready     in   1                          downstream accepts DC
// - dc_data      out  DC_WIDTH                   signed sum of all residuals of the sub-block
// - dc_idx       out  $clog2(N_BLK) (min 1)      sub-block index of dc_data
// BEHAVIOUR
// - Reset values: out_valid=0, dc_valid=0, residual=0, dc_data=0, dc_idx=0, out_last=0, out_cc=0.
//   - Row/block counters and accumulator return to 0; in_ready=0 during reset.
//   - Mid-macroblock reset discards partial state; the next accepted beat is row 0 of block 0.
// - Arithmetic per lane:
//   - Bi-pred sum is PIXEL_WIDTH+1 bits, rounded up, shifted right 1; no clipping needed.
//   - residual = {0,curr} - {0,pred}; range [-(2^PW-1), 2^PW-1].
// - Datapath is a single output register stage. Latency 1 cycle: accept at edge N, out_valid high after edge N.
//   - in_ready = (!out_valid || out_ready) && !dc_block.
//   - dc_block = dc_valid && !dc_ready && row_cnt==ROWS_PER_BLK-1 (next beat would produce a new DC).
//   - Held outputs: residual/out_last/out_cc stay stable while out_valid && !out_ready.
// - Counters advance on each accepted beat.
//   - row_cnt wraps at ROWS_PER_BLK-1; blk_cnt increments on row wrap and wraps at N_BLK-1.
//   - out_last is set on the beat with row_cnt==ROWS_PER_BLK-1 && blk_cnt==N_BLK-1.
// - DC accumulation:
//   - Lane residuals are summed per row (adder tree) into acc (DC_WIDTH, sign-extended).
//   - On the last row of a sub-block: dc_data <= acc + row_sum, dc_idx <= blk_cnt, dc_valid <= 1, acc <= 0, all on the same edge that registers the row.
//   - dc_valid clears on dc_valid&&dc_ready unless a new DC loads on that same edge; if it does, dc_valid stays 1 and the new data is shown.
// - FSM (ctrl): IDLE -> RUN on first accepted beat (latches ccin) -> RUN until the out_last beat is accepted downstream -> IDLE.
//   - Back-to-back macroblocks allowed: an accepted beat in the same cycle as the out_last handshake keeps RUN and latches the new ccin.
// - Simultaneous events: an out handshake and a new accept in the same cycle produce no bubble; full throughput is 1 beat/cycle when out_ready=dc_ready=1.
// STRUCTURE
// - Shared package mc_pkg holds:
//   - typedef pixel_t (logic [PIXEL_WIDTH-1:0]) and resid_t (logic signed [PIXEL_WIDTH:0]);
//   - enum mc_state_e {MC_IDLE, MC_RUN};
//   - localparams for default geometry.
// - One sub-module: mc_residual_lane (one lane: bi-pred average + subtract), generated ROW_PIXELS times.
// - Counters, DC accumulator, handshakes and FSM live in the top.
// TESTING
// - Uni-pred, curr=all 200, ref0=all 100, 16 beats, ready=1:
//   - residual lanes=+100 each beat, one cycle after accept;
//   - 4 DCs of 1600 with dc_idx 0..3;
//   - out_last on beat 16.
// - Bi-pred, curr=0, ref0=255, ref1=0: pred=128 -> residual=-128 (9'h180).
//   - ref0=1, ref1=0 -> pred=1, residual=-1.
// - Extremes: curr=255, ref0=0 -> residual=+255; curr=0, ref0=255 -> residual=-255 (9'h101).
//   - DC of a full negative block = -4080.
// - Backpressure: out_ready toggled randomly.
//   - in_ready low whenever the output is held; no beat lost or duplicated; outputs stable while stalled.
// - DC stall: dc_ready=0 after the first DC. in_ready drops at row 3 of block 1 and resumes the cycle after dc_ready=1.
// - Reset after beat 6 of an MB: all valids 0 next cycle; the next MB's first DC has dc_idx=0 and excludes pre-reset data.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and default geometry for the motion-compensation residual engine.
package mc_pkg;

   localparam int MC_PIXEL_WIDTH  = 8;
   localparam int MC_ROW_PIXELS   = 4;
   localparam int MC_ROWS_PER_BLK = 4;
   localparam int MC_N_BLK        = 4;
   localparam int MC_DC_WIDTH     = 16;

   typedef logic [MC_PIXEL_WIDTH-1:0]      pixel_t;
   typedef logic signed [MC_PIXEL_WIDTH:0] resid_t;

   typedef enum logic {
      MC_IDLE,
      MC_RUN
   } mc_state_e;

endpackage

// File: rtl/mc_residual_lane.sv
// One pixel lane: optional bi-pred rounding average, then signed residual curr - pred.
// Purely combinational; the top registers the result.
module mc_residual_lane
   import mc_pkg::*;
#(
   parameter int PIXEL_WIDTH = MC_PIXEL_WIDTH
) (
   input  logic [PIXEL_WIDTH-1:0]      curr,
   input  logic [PIXEL_WIDTH-1:0]      ref0,
   input  logic [PIXEL_WIDTH-1:0]      ref1,
   input  logic                        bipred,
   output logic signed [PIXEL_WIDTH:0] residual
);

   logic [PIXEL_WIDTH:0]   bi_sum;
   logic [PIXEL_WIDTH-1:0] pred;

   always_comb begin
      // One extra bit holds ref0 + ref1 + 1 exactly, so the average never clips.
      bi_sum   = {1'b0, ref0} + {1'b0, ref1} + {{PIXEL_WIDTH{1'b0}}, 1'b1};
      pred     = bipred ? bi_sum[PIXEL_WIDTH:1] : ref0;
      residual = $signed({1'b0, curr}) - $signed({1'b0, pred});
   end

endmodule

// File: rtl/mc_residual_engine.sv
// Inter-prediction residual engine: one registered residual beat per accepted row,
// plus a per-sub-block DC sum on its own valid/ready channel.
module mc_residual_engine
   import mc_pkg::*;
#(
   parameter int PIXEL_WIDTH  = MC_PIXEL_WIDTH,
   parameter int ROW_PIXELS   = MC_ROW_PIXELS,
   parameter int ROWS_PER_BLK = MC_ROWS_PER_BLK,
   parameter int N_BLK        = MC_N_BLK,
   parameter int DC_WIDTH     = MC_DC_WIDTH
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic                                   bipred,
   input  logic                                   ccin,
   input  logic [PIXEL_WIDTH*ROW_PIXELS-1:0]      curr_row,
   input  logic [PIXEL_WIDTH*ROW_PIXELS-1:0]      ref0_row,
   input  logic [PIXEL_WIDTH*ROW_PIXELS-1:0]      ref1_row,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [(PIXEL_WIDTH+1)*ROW_PIXELS-1:0]  residual,
   output logic                                   out_last,
   output logic                                   out_cc,
   output logic                                   dc_valid,
   input  logic                                   dc_ready,
   output logic [DC_WIDTH-1:0]                    dc_data,
   output logic [(N_BLK > 1 ? $clog2(N_BLK) : 1)-1:0] dc_idx
);

   localparam int LW    = PIXEL_WIDTH + 1;
   localparam int IDX_W = (N_BLK > 1) ? $clog2(N_BLK) : 1;
   localparam int ROW_W = (ROWS_PER_BLK > 1) ? $clog2(ROWS_PER_BLK) : 1;
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS_PER_BLK - 1);
   localparam logic [IDX_W-1:0] BLK_LAST = IDX_W'(N_BLK - 1);

   if (DC_WIDTH < PIXEL_WIDTH + 1 + $clog2(ROW_PIXELS * ROWS_PER_BLK)) begin : g_dc_width_check
      $error("mc_residual_engine: DC_WIDTH too narrow for a full sub-block sum");
   end

   logic                         out_valid_q, out_valid_d;
   logic [LW*ROW_PIXELS-1:0]     residual_q, residual_d;
   logic                         out_last_q, out_last_d;
   logic                         out_cc_q, out_cc_d;
   logic                         dc_valid_q, dc_valid_d;
   logic signed [DC_WIDTH-1:0]   dc_data_q, dc_data_d;
   logic [IDX_W-1:0]             dc_idx_q, dc_idx_d;
   logic [ROW_W-1:0]             row_cnt_q, row_cnt_d;
   logic [IDX_W-1:0]             blk_cnt_q, blk_cnt_d;
   logic signed [DC_WIDTH-1:0]   acc_q, acc_d;

   mc_state_e                    state_q;
   logic                         mb_cc_q;

   logic signed [LW-1:0]         lane_res [ROW_PIXELS];
   logic signed [DC_WIDTH-1:0]   row_sum;
   logic signed [DC_WIDTH-1:0]   blk_sum;
   logic                         in_acc, out_hs, dc_hs;
   logic                         last_row, last_blk, first_beat, beat_cc, dc_block;

   for (genvar g = 0; g < ROW_PIXELS; g++) begin : g_lane
      mc_residual_lane #(
         .PIXEL_WIDTH (PIXEL_WIDTH)
      ) u_lane (
         .curr     (curr_row[g*PIXEL_WIDTH +: PIXEL_WIDTH]),
         .ref0     (ref0_row[g*PIXEL_WIDTH +: PIXEL_WIDTH]),
         .ref1     (ref1_row[g*PIXEL_WIDTH +: PIXEL_WIDTH]),
         .bipred   (bipred),
         .residual (lane_res[g])
      );
   end

   always_comb begin
      row_sum = '0;
      for (int i = 0; i < ROW_PIXELS; i++) begin
         row_sum = row_sum + {{(DC_WIDTH-LW){lane_res[i][LW-1]}}, lane_res[i]};
      end
      blk_sum = acc_q + row_sum;
   end

   assign last_row   = (row_cnt_q == ROW_LAST);
   assign last_blk   = (blk_cnt_q == BLK_LAST);
   // A pending DC that has not drained must not be overwritten by the next block's DC.
   assign dc_block   = dc_valid_q && !dc_ready && last_row;
   assign in_ready   = !reset && (!out_valid_q || out_ready) && !dc_block;
   assign in_acc     = in_valid && in_ready;
   assign out_hs     = out_valid_q && out_ready;
   assign dc_hs      = dc_valid_q && dc_ready;
   assign first_beat = (state_q == MC_IDLE) || ((row_cnt_q == '0) && (blk_cnt_q == '0));
   assign beat_cc    = first_beat ? ccin : mb_cc_q;

   always_comb begin
      out_valid_d = out_valid_q;
      residual_d  = residual_q;
      out_last_d  = out_last_q;
      out_cc_d    = out_cc_q;
      dc_valid_d  = dc_valid_q;
      dc_data_d   = dc_data_q;
      dc_idx_d    = dc_idx_q;
      row_cnt_d   = row_cnt_q;
      blk_cnt_d   = blk_cnt_q;
      acc_d       = acc_q;

      if (out_hs) begin
         out_valid_d = 1'b0;
      end
      if (dc_hs) begin
         dc_valid_d = 1'b0;
      end

      if (in_acc) begin
         out_valid_d = 1'b1;
         for (int i = 0; i < ROW_PIXELS; i++) begin
            residual_d[i*LW +: LW] = lane_res[i];
         end
         out_last_d = last_row && last_blk;
         out_cc_d   = beat_cc;

         if (last_row) begin
            row_cnt_d  = '0;
            blk_cnt_d  = last_blk ? '0 : blk_cnt_q + IDX_W'(1);
            acc_d      = '0;
            dc_valid_d = 1'b1;
            dc_data_d  = blk_sum;
            dc_idx_d   = blk_cnt_q;
         end else begin
            row_cnt_d  = row_cnt_q + ROW_W'(1);
            acc_d      = blk_sum;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         residual_q  <= '0;
         out_last_q  <= 1'b0;
         out_cc_q    <= 1'b0;
         dc_valid_q  <= 1'b0;
         dc_data_q   <= '0;
         dc_idx_q    <= '0;
         row_cnt_q   <= '0;
         blk_cnt_q   <= '0;
         acc_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         residual_q  <= residual_d;
         out_last_q  <= out_last_d;
         out_cc_q    <= out_cc_d;
         dc_valid_q  <= dc_valid_d;
         dc_data_q   <= dc_data_d;
         dc_idx_q    <= dc_idx_d;
         row_cnt_q   <= row_cnt_d;
         blk_cnt_q   <= blk_cnt_d;
         acc_q       <= acc_d;
      end
   end

   // Macroblock control; a new first beat accepted alongside the out_last handshake stays in RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MC_IDLE;
         mb_cc_q <= 1'b0;
      end else begin
         case (state_q)
            MC_IDLE: begin
               if (in_acc) begin
                  state_q <= MC_RUN;
                  mb_cc_q <= ccin;
               end
            end
            MC_RUN: begin
               if (in_acc && first_beat) begin
                  mb_cc_q <= ccin;
               end
               if (out_hs && out_last_q && !in_acc) begin
                  state_q <= MC_IDLE;
               end
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign residual  = residual_q;
   assign out_last  = out_last_q;
   assign out_cc    = out_cc_q;
   assign dc_valid  = dc_valid_q;
   assign dc_data   = dc_data_q;
   assign dc_idx    = dc_idx_q;

endmodule

// File: tb/tb_mc_residual_engine.sv
// Bench for mc_residual_engine: queue-based reference model plus directed literal checks.
module tb_mc_residual_engine;

   localparam int PW  = 8;
   localparam int RP  = 4;
   localparam int RPB = 4;
   localparam int NB  = 4;
   localparam int DCW = 16;
   localparam int BPM = RPB * NB;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid, in_ready, bipred, ccin;
   logic [PW*RP-1:0] curr_row, ref0_row, ref1_row;
   logic            out_valid, out_ready, out_last, out_cc;
   logic [(PW+1)*RP-1:0] residual;
   logic            dc_valid, dc_ready;
   logic [DCW-1:0]  dc_data;
   logic [1:0]      dc_idx;

   always #5 clk = ~clk;

   mc_residual_engine #(
      .PIXEL_WIDTH (PW), .ROW_PIXELS (RP), .ROWS_PER_BLK (RPB), .N_BLK (NB), .DC_WIDTH (DCW)
   ) dut (
      .clk (clk), .reset (reset), .in_valid (in_valid), .in_ready (in_ready),
      .bipred (bipred), .ccin (ccin), .curr_row (curr_row), .ref0_row (ref0_row),
      .ref1_row (ref1_row), .out_valid (out_valid), .out_ready (out_ready),
      .residual (residual), .out_last (out_last), .out_cc (out_cc),
      .dc_valid (dc_valid), .dc_ready (dc_ready), .dc_data (dc_data), .dc_idx (dc_idx)
   );

   typedef struct {
      logic [(PW+1)*RP-1:0] res;
      logic                 last;
      logic                 cc;
   } beat_t;

   typedef struct {
      logic [DCW-1:0] sum;
      logic [1:0]     idx;
   } dc_t;

   beat_t               rq[$];
   dc_t                 dq[$];
   logic [(PW+1)*RP-1:0] obs_res[$];
   logic                obs_last[$];
   logic [DCW-1:0]      obs_dc[$];
   logic [1:0]          obs_idx[$];

   int   checks = 0;
   int   errors = 0;
   int   mdl_beat = 0;
   int   mdl_acc = 0;
   logic mdl_cc = 1'b0;
   int   n_acc = 0;
   int   n_stall = 0;
   int   cyc = 0;
   bit   done = 1'b0;
   bit   rnd = 1'b0;

   function automatic int exp_res(int c, int r0, int r1, bit bp);
      int pred;
      pred = bp ? (r0 + r1 + 1) / 2 : r0;
      return c - pred;
   endfunction

   task automatic chk(string name, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic model_accept();
      beat_t     b;
      dc_t       d;
      int        s, r, q;
      logic [PW:0] rv;
      s = 0;
      if (mdl_beat == 0) mdl_cc = ccin;
      for (int i = 0; i < RP; i++) begin
         r = exp_res(int'(curr_row[i*PW +: PW]), int'(ref0_row[i*PW +: PW]),
                     int'(ref1_row[i*PW +: PW]), bipred);
         rv = r[PW:0];
         b.res[i*(PW+1) +: PW+1] = rv;
         s += r;
      end
      b.last = (mdl_beat == BPM - 1);
      b.cc   = mdl_cc;
      rq.push_back(b);
      n_acc++;
      mdl_acc += s;
      if (mdl_beat % RPB == RPB - 1) begin
         q     = mdl_beat / RPB;
         d.sum = mdl_acc[DCW-1:0];
         d.idx = q[1:0];
         dq.push_back(d);
         mdl_acc = 0;
      end
      mdl_beat = (mdl_beat + 1) % BPM;
   endtask

   task automatic monitor();
      bit exp_rdy;
      while (!done) begin
         @(negedge clk);
         cyc++;
         if (cyc > 60000) begin
            $display("FAIL watchdog cycles=%0d required<60000", cyc);
            $fatal(1, "bench watchdog expired");
         end
         if (reset) begin
            chk("rst_in_ready", in_ready, 0);
            rq.delete();
            dq.delete();
            mdl_beat = 0;
            mdl_acc  = 0;
         end else begin
            chk("out_valid", out_valid, rq.size() != 0);
            if (out_valid && rq.size() != 0) begin
               chk("residual", residual, rq[0].res);
               chk("out_last", out_last, rq[0].last);
               chk("out_cc", out_cc, rq[0].cc);
            end
            chk("dc_valid", dc_valid, dq.size() != 0);
            if (dc_valid && dq.size() != 0) begin
               chk("dc_data", dc_data, dq[0].sum);
               chk("dc_idx", dc_idx, dq[0].idx);
            end
            exp_rdy = (rq.size() == 0 || out_ready) &&
                      !(dq.size() != 0 && !dc_ready && (mdl_beat % RPB == RPB - 1));
            chk("in_ready", in_ready, exp_rdy);
            if (in_valid && !in_ready) n_stall++;
            if (out_valid && out_ready && rq.size() != 0) begin
               obs_res.push_back(residual);
               obs_last.push_back(out_last);
               void'(rq.pop_front());
            end
            if (dc_valid && dc_ready && dq.size() != 0) begin
               obs_dc.push_back(dc_data);
               obs_idx.push_back(dc_idx);
               void'(dq.pop_front());
            end
            if (in_valid && in_ready) model_accept();
         end
      end
   endtask

   task automatic shake();
      if (rnd) begin
         out_ready = 1'($urandom_range(0, 1));
         dc_ready  = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic send_beat(logic [PW*RP-1:0] c, logic [PW*RP-1:0] r0,
                            logic [PW*RP-1:0] r1, logic bp, logic cc);
      bit got;
      int budget;
      got = 1'b0;
      budget = 0;
      in_valid = 1'b1; curr_row = c; ref0_row = r0; ref1_row = r1; bipred = bp; ccin = cc;
      while (!got && budget < 300) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
         budget++;
         shake();
      end
      chk("send_accept_timeout", got, 1);
      in_valid = 1'b0;
   endtask

   task automatic idle(int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
         shake();
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      dc_ready  = 1'b1;
      in_valid  = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dc_valid", dc_valid, 0);
      chk("rst_residual", residual, 0);
      chk("rst_dc_data", dc_data, 0);
      chk("rst_dc_idx", dc_idx, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_cc", out_cc, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic stimulus();
      int rb, db, sb, ab;

      chk("mdl_bi_half", exp_res(0, 255, 0, 1'b1), -128);
      chk("mdl_bi_one", exp_res(0, 1, 0, 1'b1), -1);
      chk("mdl_pos_max", exp_res(255, 0, 0, 1'b0), 255);
      chk("mdl_neg_max", exp_res(0, 255, 9, 1'b0), -255);

      // Uni-pred macroblock at full rate.
      do_reset();
      rb = obs_res.size(); db = obs_dc.size(); sb = n_stall;
      for (int i = 0; i < BPM; i++) send_beat({4{8'd200}}, {4{8'd100}}, '0, 1'b0, 1'b1);
      drain();
      chk("t1_beats", obs_res.size() - rb, 16);
      for (int i = 0; i < BPM; i++) begin
         chk("t1_res", obs_res[rb+i], {4{9'd100}});
         chk("t1_last", obs_last[rb+i], i == 15);
      end
      chk("t1_dc_count", obs_dc.size() - db, 4);
      for (int i = 0; i < NB; i++) begin
         chk("t1_dc", obs_dc[db+i], 1600);
         chk("t1_dc_idx", obs_idx[db+i], i);
      end
      chk("t1_no_stall", n_stall - sb, 0);

      // Bi-pred rounding.
      do_reset();
      rb = obs_res.size();
      send_beat('0, {4{8'd255}}, '0, 1'b1, 1'b0);
      send_beat('0, {4{8'd1}}, '0, 1'b1, 1'b0);
      drain();
      chk("t2_bi_128", obs_res[rb], {4{9'h180}});
      chk("t2_bi_1", obs_res[rb+1], {4{9'h1FF}});

      // Extremes and a fully negative block.
      do_reset();
      rb = obs_res.size(); db = obs_dc.size();
      for (int i = 0; i < RPB; i++) send_beat('0, {4{8'd255}}, {4{8'd77}}, 1'b0, 1'b0);
      send_beat({4{8'd255}}, '0, '0, 1'b0, 1'b0);
      drain();
      chk("t3_neg_max", obs_res[rb], {4{9'h101}});
      chk("t3_pos_max", obs_res[rb+4], {4{9'h0FF}});
      chk("t3_dc_neg", obs_dc[db], 16'hF010);
      chk("t3_dc_neg_idx", obs_idx[db], 0);

      // DC channel stalled: intake stops at row 3 of block 1.
      do_reset();
      ab = n_acc;
      out_ready = 1'b1;
      dc_ready  = 1'b0;
      fork
         begin
            for (int i = 0; i < BPM; i++) send_beat({4{8'd90}}, {4{8'd30}}, {4{8'd60}}, 1'b1, 1'b1);
         end
         begin
            repeat (20) @(posedge clk);
            #1;
            chk("t4_stall_accepted", n_acc - ab, 7);
            chk("t4_stall_in_ready", in_ready, 0);
            dc_ready = 1'b1;
         end
      join
      drain();
      chk("t4_total", n_acc - ab, 16);

      // Random data, gaps and backpressure on both output channels.
      do_reset();
      rnd = 1'b1;
      for (int i = 0; i < 400; i++) begin
         send_beat($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      rnd = 1'b0;
      drain();

      // Reset in the middle of a macroblock.
      do_reset();
      for (int i = 0; i < 6; i++) send_beat({4{8'd50}}, {4{8'd10}}, '0, 1'b0, 1'b1);
      do_reset();
      db = obs_dc.size();
      for (int i = 0; i < BPM; i++) send_beat({4{8'd200}}, {4{8'd100}}, '0, 1'b0, 1'b0);
      drain();
      chk("t6_first_dc", obs_dc[db], 1600);
      chk("t6_first_idx", obs_idx[db], 0);

      done = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; bipred = 1'b0; ccin = 1'b0;
      curr_row = '0; ref0_row = '0; ref1_row = '0;
      out_ready = 1'b1; dc_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      fork
         monitor();
         stimulus();
      join
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
